core_mem_arbiter: RTL and testbench
===================================

# core_mem_arbiter

Round-robin arbiter that shares one single-port synchronous data memory among the multiplier cores of the multi-core processor. Each cycle it accepts at most one read or write from the requesting cores, drives the memory port from registers, and routes read data back to the issuing core. It also aggregates the per-core ENDOP indications into a single sticky `all_done` flag for the top level and the bench.

## Interface
- `NUM_CORES`, 4, number of requesting cores (2..8)
- `ADDR_W`, 12, memory address width
- `DATA_W`, 8, memory data width
- `MAX_BURST`, 4, consecutive grants one core may hold (only with `ARB_BURST_EN`)

- `clk` in 1, single clock, all logic on rising edge
- `rst_n` in 1, asynchronous active-low reset
- `req` in NUM_CORES, per-core access request
- `we` in NUM_CORES, per-core write enable (1 = write, 0 = read)
- `addr` in NUM_CORES*ADDR_W, core i occupies bits [i*ADDR_W +: ADDR_W]
- `wdata` in NUM_CORES*DATA_W, core i occupies bits [i*DATA_W +: DATA_W]
- `core_end` in NUM_CORES, pulse or level from core i when it decodes ENDOP (opcode 28)
- `gnt` out NUM_CORES, one-hot; the request core i presented in the previous cycle is accepted
- `rvalid` out NUM_CORES, one-hot; `rdata` holds core i's read result
- `rdata` out DATA_W, combinational pass-through of `mem_rdata`
- `mem_en` out 1, memory access strobe
- `mem_we` out 1, memory write enable
- `mem_addr` out ADDR_W, memory address
- `mem_wdata` out DATA_W, memory write data
- `mem_rdata` in DATA_W, memory read data, valid one cycle after a `mem_en` read
- `all_done` out 1, sticky; every core has signalled `core_end`

## Operation
- Reset values: `gnt`=0, `rvalid`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `all_done`=0. The round-robin pointer is set to core NUM_CORES-1, so core 0 has first priority. The burst counter and the done latches are 0.
- Arbitration at each edge: the winner is the first core with `req`=1, searching upward from (pointer+1) mod NUM_CORES.
  - The winner's `gnt` bit is registered high for exactly one cycle.
  - The winner's `we`, `addr` and `wdata` are registered onto the `mem_*` outputs, and `mem_en` is set to 1.
  - The pointer is updated to the winner.
- No requester, or `all_done`=1: `gnt`=0 and `mem_en`=0.
- Core contract:
  - Hold `req`, `we`, `addr` and `wdata` stable until `gnt` is seen.
  - In the `gnt` cycle, either present the next request or drop `req`.
  - A request still high in the `gnt` cycle is a new access.
- Read return: `rvalid` is a one-hot copy of the read grant, delayed one cycle, with `rdata` = `mem_rdata`. Writes never raise `rvalid`.
- Fairness: a continuously requesting core waits at most NUM_CORES-1 grants.
- Done logic:
  - Each core has a sticky latch, set by `core_end[i]`.
  - `all_done` is set when all latches are 1.
  - Only reset clears the latches and `all_done`.
  - Once `all_done`=1, no further grants are issued. An access already issued still completes its `rvalid`.

## Timing
- Request presented in cycle t, then `gnt` and `mem_en` in cycle t+1, then `rvalid` and `rdata` in cycle t+2 for a read.
- Throughput: one access per cycle across all cores.
- Write in cycle t+1 followed by a read of the same address granted in t+2: the read returns the new data. This relies on memory write-before-read ordering; the arbiter adds no bypass.
- Simultaneous requests from all cores: grants follow pointer order, one per cycle, with no idle cycles.
- Reset asserted mid-access: all outputs clear immediately (asynchronously); a pending `rvalid` is discarded, not replayed.
- `core_end` arriving in the same cycle as a request: that request is still arbitrated if `all_done` was 0 at the edge.

## Configuration
- `ARB_BURST_EN`
  - Defined: if the last-granted core still requests, it is re-granted ahead of round-robin order. This repeats for up to MAX_BURST consecutive grants; the pointer then forces the next requester.
  - The burst counter resets whenever the grant changes core or an idle cycle occurs.
  - Undefined: strict round robin; the pointer advances after every grant.

## Test plan
- Single core 0 reads addr 0x005, where memory holds 0x3C: `gnt`=0001 at t+1 and `mem_addr`=0x005, `mem_we`=0. Then `rvalid`=0001 and `rdata`=0x3C at t+2.
- All 4 cores request continuously after reset, without the macro: grant order is 0,1,2,3,0,1, one grant per cycle, and no core is granted twice in a row.
- Same stimulus with `ARB_BURST_EN` and MAX_BURST=4: core 0 is granted 4 consecutive cycles, then core 1 four cycles, and so on.
- Core 2 writes 0xA5 to 0x010, then core 3 reads 0x010 in the next grant slot: `rvalid`=1000 and `rdata`=0xA5.
- `core_end` pulsed on cores 0..3 at different cycles: `all_done` rises one cycle after the last pulse. Subsequent requests get no `gnt` and `mem_en` stays 0.
- `rst_n` dropped while a read is outstanding: `rvalid`, `gnt`, `mem_en` and `all_done` go to 0 without waiting for a clock edge. After release, the first grant goes to core 0.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory among NUM_CORES cores,
// plus sticky all_done aggregation. Define ARB_BURST_EN to let a core hold up to MAX_BURST grants.
module core_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req_i,
  input  logic [NUM_CORES-1:0]        we_i,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_i,
  input  logic [NUM_CORES*DATA_W-1:0] wdata_i,
  input  logic [NUM_CORES-1:0]        core_end_i,
  output logic [NUM_CORES-1:0]        gnt_o,
  output logic [NUM_CORES-1:0]        rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  output logic                        all_done_o
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
`ifdef ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic [NUM_CORES-1:0] gnt_q, gnt_d;
  logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic [NUM_CORES-1:0] done_q, done_d;
  logic                 all_done_q, all_done_d;

  logic                 win_valid;
  logic [IDX_W-1:0]     win_idx;
  logic                 grant_en;
  logic                 same_core;

  // Round-robin search starting just after the last winner; ptr itself is checked last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      logic [IDX_W:0] cand;
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_CORES)) cand = cand - (IDX_W+1)'(NUM_CORES);
      if (!win_valid && req_i[cand[IDX_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
    // A nonzero count means ptr_q was granted in the previous cycle.
    if (BURST_EN && burst_cnt_q != '0 && burst_cnt_q < CNT_W'(MAX_BURST) && req_i[ptr_q]) begin
      win_valid = 1'b1;
      win_idx   = ptr_q;
    end
  end

  assign grant_en  = win_valid && !all_done_q;
  assign same_core = (burst_cnt_q != '0) && (win_idx == ptr_q);

  always_comb begin
    gnt_d       = '0;
    mem_en_d    = grant_en;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ptr_d       = ptr_q;
    burst_cnt_d = '0;
    if (grant_en) begin
      gnt_d[win_idx] = 1'b1;
      mem_we_d       = we_i[win_idx];
      mem_addr_d     = addr_i[win_idx*ADDR_W +: ADDR_W];
      mem_wdata_d    = wdata_i[win_idx*DATA_W +: DATA_W];
      ptr_d          = win_idx;
      if (BURST_EN) burst_cnt_d = same_core ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
    end
    rvalid_d   = mem_we_q ? '0 : gnt_q;
    done_d     = done_q | core_end_i;
    all_done_d = all_done_q | (&done_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ptr_q       <= IDX_W'(NUM_CORES - 1);
      burst_cnt_q <= '0;
      done_q      <= '0;
      all_done_q  <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      done_q      <= done_d;
      all_done_q  <= all_done_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = mem_rdata_i;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign all_done_o  = all_done_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: vector table of single-core accesses, round-robin order,
// done aggregation and asynchronous reset; read returns go through a scoreboard queue.
module tb_core_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0, we = '0, core_end = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, mem_rdata;
  logic            mem_en, mem_we, all_done;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem [0:(1<<AW)-1];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .core_end_i(core_end), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .all_done_o(all_done));

  // Single-port synchronous memory, write-before-read across cycles.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [N-1:0] rv; logic [DW-1:0] data; } sb_t;
  sb_t sbq[$];

  always @(negedge clk) begin
    if (rst_n && rvalid !== '0) begin
      if (sbq.size() == 0) begin
        check("rvalid_unexpected", 32'(rvalid), 32'h0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("rvalid", 32'(rvalid), 32'(e.rv));
        check("rdata", 32'(rdata), 32'(e.data));
      end
    end
  end

  typedef struct {
    int            core;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t vecs[6];

  task automatic drive_one(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req = '0;
    req[c] = 1'b1;
    we[c] = w;
    addr[c*AW +: AW] = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    req = '0; we = '0; core_end = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[8];
    logic [N-1:0] exp_g;

    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'(i * 7);
    mem[12'h005] = 8'h3C;
    mem[12'hFFF] = 8'h77;
    mem_rdata = '0;

    vecs[0] = '{0, 1'b0, 12'h005, 8'h00, 8'h3C};
    vecs[1] = '{2, 1'b1, 12'h010, 8'hA5, 8'h00};
    vecs[2] = '{3, 1'b0, 12'h010, 8'h00, 8'hA5};
    vecs[3] = '{1, 1'b1, 12'h123, 8'h5A, 8'h00};
    vecs[4] = '{1, 1'b0, 12'h123, 8'h00, 8'h5A};
    vecs[5] = '{0, 1'b0, 12'hFFF, 8'h00, 8'h77};
`ifdef ARB_BURST_EN
    order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_all_done", 32'(all_done), 32'h0);
    step();
    rst_n = 1'b1;

    // Back-to-back single-core accesses; each next request is presented in the gnt cycle.
    step();
    for (int i = 0; i < 6; i++) begin
      drive_one(vecs[i].core, vecs[i].w, vecs[i].a, vecs[i].d);
      if (!vecs[i].w) sbq.push_back('{N'(1) << vecs[i].core, vecs[i].exp_rd});
      step();
      exp_g = N'(1) << vecs[i].core;
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(exp_g));
      check($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'h1);
      check($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].w));
      check($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].a));
      if (vecs[i].w) check($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].d));
    end
    req = '0;
    step();
    check("idle_mem_en", 32'(mem_en), 32'h0);
    check("idle_gnt", 32'(gnt), 32'h0);
    repeat (3) step();
    check("sb_drained_table", 32'(sbq.size()), 32'h0);

    // All cores request continuously (writes, so no read returns).
    reset_dut();
    for (int c = 0; c < N; c++) begin
      addr[c*AW +: AW] = AW'(12'h100 + c);
      wdata[c*DW +: DW] = DW'(8'h10 + c);
    end
    we = '1;
    req = '1;
    for (int j = 0; j < 8; j++) begin
      step();
      exp_g = N'(1) << order[j];
      check($sformatf("rr%0d_gnt", j), 32'(gnt), 32'(exp_g));
      check($sformatf("rr%0d_mem_en", j), 32'(mem_en), 32'h1);
    end
    req = '0; we = '0;
    repeat (2) step();

    // Done latches pulsed at different cycles; grants stop afterwards.
    reset_dut();
    step();
    core_end = 4'b0001; step(); core_end = '0;
    check("done_after_c0", 32'(all_done), 32'h0);
    step();
    core_end = 4'b0100; step(); core_end = '0;
    check("done_after_c2", 32'(all_done), 32'h0);
    core_end = 4'b0010; step(); core_end = '0;
    check("done_after_c1", 32'(all_done), 32'h0);
    step();
    check("done_idle", 32'(all_done), 32'h0);
    core_end = 4'b1000; step(); core_end = '0;
    check("done_after_c3", 32'(all_done), 32'h1);
    drive_one(2, 1'b0, 12'h005, 8'h00);
    for (int j = 0; j < 3; j++) begin
      step();
      check($sformatf("done_blk%0d_gnt", j), 32'(gnt), 32'h0);
      check($sformatf("done_blk%0d_mem_en", j), 32'(mem_en), 32'h0);
      check($sformatf("done_blk%0d_sticky", j), 32'(all_done), 32'h1);
    end
    req = '0;

    // Final core_end coincides with a read request, then reset while that read is outstanding.
    reset_dut();
    core_end = 4'b0111; step(); core_end = '0;
    core_end = 4'b1000;
    drive_one(1, 1'b0, 12'h005, 8'h00);
    step();
    core_end = '0; req = '0;
    check("last_req_gnt", 32'(gnt), 32'h2);
    check("last_req_mem_en", 32'(mem_en), 32'h1);
    check("last_req_all_done", 32'(all_done), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_rvalid", 32'(rvalid), 32'h0);
    check("async_rst_mem_en", 32'(mem_en), 32'h0);
    check("async_rst_all_done", 32'(all_done), 32'h0);
    step();
    check("rst_rvalid_discarded", 32'(rvalid), 32'h0);
    rst_n = 1'b1;
    we = '1;
    req = '1;
    step();
    check("post_rst_first_gnt", 32'(gnt), 32'h1);
    req = '0; we = '0;
    repeat (3) step();
    check("sb_drained_end", 32'(sbq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
